// File: rtl/cdb_writeback_arbiter.sv
// rtl/cdb_writeback_arbiter.sv - round-robin CDB writeback arbiter with register status table
module cdb_writeback_arbiter #(
  parameter int NSRC  = 3,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC-1:0]       src_valid,
  input  logic [NSRC*TAG_W-1:0] src_tag,
  input  logic [NSRC*5-1:0]     src_rd,
  input  logic [NSRC*32-1:0]    src_data,
  output logic [NSRC-1:0]       src_ready,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [TAG_W-1:0]      issue_tag,
  input  logic [4:0]            look_addr1,
  input  logic [4:0]            look_addr2,
  output logic                  look_busy1,
  output logic                  look_busy2,
  output logic [TAG_W-1:0]      look_tag1,
  output logic [TAG_W-1:0]      look_tag2,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [31:0]           cdb_data,
  output logic                  reg_write,
  output logic [4:0]            reg_waddr,
  output logic [31:0]           reg_wdata
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [31:0]               busy_q, busy_d;
  logic [31:0][TAG_W-1:0]    tag_q, tag_d;
  logic                      cdb_valid_q;
  logic [TAG_W-1:0]          cdb_tag_q;
  logic [31:0]               cdb_data_q;
  logic                      reg_write_q;
  logic [4:0]                reg_waddr_q;
  logic [31:0]               reg_wdata_q;

  logic [NSRC-1:0]           gnt;
  logic [PW-1:0]             gnt_idx;
  logic                      gnt_any;
  logic                      xfer;
  logic [TAG_W-1:0]          sel_tag;
  logic [4:0]                sel_rd;
  logic [31:0]               sel_data;
  logic                      iss_en;
  logic                      wr_ok;

  // Pick the first valid source at or after the round-robin pointer, wrapping cyclically.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!gnt_any && src_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    gnt = gnt_any ? (NSRC'(1) << gnt_idx) : '0;
  end

  assign src_ready = rst ? '0 : gnt;
  assign xfer      = gnt_any && !rst;
  assign sel_tag   = src_tag[int'(gnt_idx)*TAG_W +: TAG_W];
  assign sel_rd    = src_rd[int'(gnt_idx)*5 +: 5];
  assign sel_data  = src_data[int'(gnt_idx)*32 +: 32];
  assign iss_en    = issue_valid && (issue_rd != 5'd0);

  // A writeback only retires the register if it is still the newest producer and no
  // rename to the same register lands on this edge.
  assign wr_ok = xfer && (sel_rd != 5'd0) && busy_q[sel_rd] && (tag_q[sel_rd] == sel_tag) &&
                 !(iss_en && (issue_rd == sel_rd));

  // Status table and pointer next state; issue is applied last so it wins a same-rd collision.
  always_comb begin
    busy_d   = busy_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (wr_ok) busy_d[sel_rd] = 1'b0;
    if (iss_en) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
    if (xfer) rr_ptr_d = (gnt_idx == PW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // State registers and registered broadcast / register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      tag_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      reg_write_q <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      cdb_valid_q <= xfer;
      reg_write_q <= wr_ok;
      if (xfer) begin
        cdb_tag_q   <= sel_tag;
        cdb_data_q  <= sel_data;
        reg_waddr_q <= sel_rd;
        reg_wdata_q <= sel_data;
      end
    end
  end

  assign look_busy1 = (look_addr1 != 5'd0) && busy_q[look_addr1];
  assign look_busy2 = (look_addr2 != 5'd0) && busy_q[look_addr2];
  assign look_tag1  = tag_q[look_addr1];
  assign look_tag2  = tag_q[look_addr2];

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign reg_write = reg_write_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb/tb_cdb_writeback_arbiter.sv - scoreboard bench for cdb_writeback_arbiter
module tb_cdb_writeback_arbiter;

  localparam int NSRC  = 3;
  localparam int TAG_W = 4;

  logic                  clk;
  logic                  rst;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC*TAG_W-1:0] src_tag;
  logic [NSRC*5-1:0]     src_rd;
  logic [NSRC*32-1:0]    src_data;
  logic [NSRC-1:0]       src_ready;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic [TAG_W-1:0]      issue_tag;
  logic [4:0]            look_addr1, look_addr2;
  logic                  look_busy1, look_busy2;
  logic [TAG_W-1:0]      look_tag1, look_tag2;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [31:0]           cdb_data;
  logic                  reg_write;
  logic [4:0]            reg_waddr;
  logic [31:0]           reg_wdata;

  cdb_writeback_arbiter #(.NSRC(NSRC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_tag(src_tag), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .look_addr1(look_addr1), .look_addr2(look_addr2),
    .look_busy1(look_busy1), .look_busy2(look_busy2),
    .look_tag1(look_tag1), .look_tag2(look_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .reg_write(reg_write), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             wr;
    logic [4:0]       addr;
    logic [31:0]      wdata;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [4:0] rd,
                         input logic [31:0] d);
    src_tag[i*TAG_W +: TAG_W] = t;
    src_rd[i*5 +: 5]          = rd;
    src_data[i*32 +: 32]      = d;
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [31:0] d, input logic wr,
                      input logic [4:0] a);
    exp_t e;
    e.tag = t; e.data = d; e.wr = wr; e.addr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  // Monitor: every broadcast must match the oldest expected entry.
  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("cdb_unexpected", {63'd0, cdb_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
        chk("cdb_data", 64'(cdb_data), 64'(e.data));
        chk("reg_write", 64'(reg_write), 64'(e.wr));
        chk("reg_waddr", 64'(reg_waddr), 64'(e.addr));
        chk("reg_wdata", 64'(reg_wdata), 64'(e.wdata));
      end
    end
  end

  initial begin
    rst = 1'b1; src_valid = 3'b111; src_tag = '0; src_rd = '0; src_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0; look_addr1 = '0; look_addr2 = '0;
    cyc();
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    rst = 1'b0; src_valid = '0;

    // Basic rename then matching writeback
    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    cyc();
    issue_valid = 1'b0;
    set_src(0, 4'd3, 5'd5, 32'hDEADBEEF);
    src_valid = 3'b001; look_addr1 = 5'd5;
    #1;
    chk("t1_ready", 64'(src_ready), 64'b001);
    chk("t1_busy_pre", 64'(look_busy1), 64'd1);
    chk("t1_tag_pre", 64'(look_tag1), 64'd3);
    push(4'd3, 32'hDEADBEEF, 1'b1, 5'd5);
    cyc();
    src_valid = '0;
    #1;
    chk("t1_busy_post", 64'(look_busy1), 64'd0);

    // Round robin from reset, then skipping a dropped source
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_src(0, 4'd1, 5'd10, 32'h1000);
    set_src(1, 4'd2, 5'd11, 32'h2000);
    set_src(2, 4'd3, 5'd12, 32'h3000);
    src_valid = 3'b111;
    #1; chk("rr_g0", 64'(src_ready), 64'b001); push(4'd1, 32'h1000, 1'b0, 5'd10); cyc();
    #1; chk("rr_g1", 64'(src_ready), 64'b010); push(4'd2, 32'h2000, 1'b0, 5'd11); cyc();
    #1; chk("rr_g2", 64'(src_ready), 64'b100); push(4'd3, 32'h3000, 1'b0, 5'd12); cyc();
    #1; chk("rr_g3", 64'(src_ready), 64'b001); push(4'd1, 32'h1000, 1'b0, 5'd10); cyc();
    src_valid = 3'b101;
    #1; chk("rr_skip1", 64'(src_ready), 64'b100); push(4'd3, 32'h3000, 1'b0, 5'd12); cyc();
    src_valid = 3'b110;
    #1; chk("rr_skip0", 64'(src_ready), 64'b010); push(4'd2, 32'h2000, 1'b0, 5'd11); cyc();
    src_valid = '0;
    #1; chk("idle_ready", 64'(src_ready), 64'd0);
    cyc();

    // Stale writeback after re-rename of rd7 (pointer is at source 2)
    issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd2; cyc();
    issue_tag = 4'd9; cyc();
    issue_valid = 1'b0;
    set_src(0, 4'd2, 5'd7, 32'h77);
    src_valid = 3'b001;
    #1; chk("t3_ready", 64'(src_ready), 64'b001);
    push(4'd2, 32'h77, 1'b0, 5'd7);
    cyc();
    src_valid = '0; look_addr1 = 5'd7;
    #1;
    chk("t3_busy7", 64'(look_busy1), 64'd1);
    chk("t3_tag7", 64'(look_tag1), 64'd9);

    // Same-edge issue and writeback: same rd, then different rd (pointer at source 1)
    issue_valid = 1'b1; issue_rd = 5'd8; issue_tag = 4'd4; cyc();
    issue_rd = 5'd8; issue_tag = 4'd6;
    set_src(1, 4'd4, 5'd8, 32'h88);
    src_valid = 3'b010; look_addr2 = 5'd8;
    #1;
    chk("t4_ready", 64'(src_ready), 64'b010);
    chk("t4_nobypass_tag", 64'(look_tag2), 64'd4);
    push(4'd4, 32'h88, 1'b0, 5'd8);
    cyc();
    #1;
    chk("t4_busy8", 64'(look_busy2), 64'd1);
    chk("t4_tag8", 64'(look_tag2), 64'd6);
    issue_rd = 5'd9; issue_tag = 4'd5;
    set_src(2, 4'd6, 5'd8, 32'h99);
    src_valid = 3'b100;
    #1; chk("t4b_ready", 64'(src_ready), 64'b100);
    push(4'd6, 32'h99, 1'b1, 5'd8);
    cyc();
    issue_valid = 1'b0; src_valid = '0; look_addr1 = 5'd9;
    #1;
    chk("t4b_busy8", 64'(look_busy2), 64'd0);
    chk("t4b_busy9", 64'(look_busy1), 64'd1);
    chk("t4b_tag9", 64'(look_tag1), 64'd5);

    // x0: writeback and issue both to register 0 (pointer at source 0)
    issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd1;
    set_src(0, 4'd7, 5'd0, 32'h55);
    src_valid = 3'b001;
    #1; chk("t5_ready", 64'(src_ready), 64'b001);
    push(4'd7, 32'h55, 1'b0, 5'd0);
    cyc();
    issue_valid = 1'b0; src_valid = '0; look_addr1 = 5'd0;
    #1; chk("t5_busy0", 64'(look_busy1), 64'd0);
    cyc();

    // Reset mid-stream with busy entries, valid sources and an issue
    set_src(0, 4'd1, 5'd10, 32'h1000);
    set_src(1, 4'd2, 5'd11, 32'h2000);
    set_src(2, 4'd3, 5'd12, 32'h3000);
    src_valid = 3'b111; issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd2; rst = 1'b1;
    #1; chk("t6_ready_in_rst", 64'(src_ready), 64'd0);
    cyc();
    rst = 1'b0; src_valid = '0; issue_valid = 1'b0; look_addr1 = 5'd7; look_addr2 = 5'd9;
    #1;
    chk("t6_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("t6_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("t6_cdb_data", 64'(cdb_data), 64'd0);
    chk("t6_reg_write", 64'(reg_write), 64'd0);
    chk("t6_reg_waddr", 64'(reg_waddr), 64'd0);
    chk("t6_reg_wdata", 64'(reg_wdata), 64'd0);
    chk("t6_busy7", 64'(look_busy1), 64'd0);
    chk("t6_busy9", 64'(look_busy2), 64'd0);
    chk("t6_tag7", 64'(look_tag1), 64'd0);
    look_addr1 = 5'd3;
    #1; chk("t6_busy3", 64'(look_busy1), 64'd0);
    src_valid = 3'b111;
    #1; chk("t6_first_grant", 64'(src_ready), 64'b001);
    push(4'd1, 32'h1000, 1'b0, 5'd10);
    cyc();
    src_valid = '0;
    repeat (3) cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
